main_memory: RTL and testbench
==============================

MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to response; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BLOCKS_LOG2, default 6: number of 128-bit block address bits; storage = 2^ADDR_BLOCKS_LOG2 blocks.
REQ-003 SHALL have port clock, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: requester presents a block transaction.
REQ-006 SHALL have port req_write, input, 1: 1 = writeback of req_data, 0 = block refill read.
REQ-007 SHALL have port req_addr, input, 32: byte address; bits [3:0] ignored, block index = bits [ADDR_BLOCKS_LOG2+3:4], higher bits ignored (aliasing).
REQ-008 SHALL have port req_data, input, 128: block to store on write; word 0 in bits [31:0].
REQ-009 SHALL have port req_ready, output, 1: memory can accept a request this cycle.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse for reads and writes.
REQ-011 SHALL have port resp_data, output, 128: block read; same word order as req_data.
REQ-012 SHALL have port busy, output, 1: transaction in flight.
REQ-013 SHALL have ports read_count and write_count, output, 16 each: completed transaction counts.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, DONE.
REQ-015 IDLE: req_ready=1, busy=0; on req_valid at rising edge, latch req_write, block index and req_data, load countdown to LATENCY-1, and go to WAIT, or to DONE directly when LATENCY=1.
REQ-016 WAIT: req_ready=0, busy=1; decrement countdown each edge; at countdown 0 go to DONE; req_valid ignored, not queued.
REQ-017 DONE edge: write stores latched data to block index; read loads block into resp_data; resp_valid=1 for the following cycle only; state returns to IDLE.
REQ-018 Response timing: request accepted at edge N SHALL give resp_valid high in the cycle after edge N+LATENCY; req_ready high in that same cycle, so back-to-back accept at edge N+LATENCY+1.
REQ-019 Read-after-write to the same block SHALL return the newly written data.
REQ-020 On write completion resp_data SHALL keep its previous value.
REQ-021 read_count/write_count SHALL increment at DONE for the matching type and saturate at 16'hFFFF.
REQ-022 req_data/req_addr changes after acceptance SHALL NOT affect the in-flight transaction.
REQ-023 Storage SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-024 reset low SHALL immediately force state IDLE, countdown 0, resp_valid 0, resp_data 0, busy 0, read_count 0, write_count 0.
REQ-025 req_ready SHALL be 0 while reset is low, and 1 from the first cycle after release.
REQ-026 reset asserted mid-transaction SHALL abort it: in-flight write not stored, no resp_valid pulse, counters stay cleared.

Verification
REQ-027 LATENCY=4: write addr 0x00000010, data 128'h0123..CDEF accepted at edge 1 -> resp_valid only in cycle after edge 5; write_count=1; req_ready low edges 2..5.
REQ-028 Read addr 0x0000001C after REQ-027 -> resp_data=128'h0123..CDEF, read_count=1; read of untouched addr 0x20 -> 0.
REQ-029 ADDR_BLOCKS_LOG2=6: write 0x00000400 (aliases block 0) then read 0x00000000 -> same data returned.
REQ-030 req_valid held high while busy with a second address -> ignored until req_ready; second transaction accepted exactly at edge N+LATENCY+1.
REQ-031 Write in flight, reset pulsed low at edge 3 -> no resp_valid, later read of that block returns old contents, counters 0.
REQ-032 LATENCY=1: consecutive reads accepted every 2 cycles; write_count forced near 16'hFFFF saturates, no wrap.

Source files
------------

// File: rtl/main_memory.sv
// main_memory: block-oriented backing store with a fixed access latency.
// Each transaction moves one 128-bit block (four 32-bit words, word 0 in
// bits [31:0]). A single transaction is in flight at a time. The request is
// captured when accepted and the completion is reported with a one-cycle
// resp_valid pulse exactly LATENCY cycles later.
//
// Parameters
//   LATENCY          cycles from acceptance to response (1..15)
//   ADDR_BLOCKS_LOG2 number of block index bits; 2^ADDR_BLOCKS_LOG2 blocks
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    requester presents a transaction
//   req_write    1 = write back req_data, 0 = refill read
//   req_addr     byte address; block index = [ADDR_BLOCKS_LOG2+3:4]
//   req_data     block to store on a write
//   req_ready    memory accepts a request this cycle
//   resp_valid   one-cycle completion pulse for reads and writes
//   resp_data    last block read (held across write completions)
//   busy         transaction in flight
//   read_count   completed reads, saturating
//   write_count  completed writes, saturating
module main_memory #(
  parameter int LATENCY          = 4,
  parameter int ADDR_BLOCKS_LOG2 = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_data,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic         busy,
  output logic [15:0]  read_count,
  output logic [15:0]  write_count
);

  localparam int          BLOCKS     = 1 << ADDR_BLOCKS_LOG2;
  localparam logic [3:0]  LOAD_COUNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [3:0]                    countdown;
  logic [3:0]                    countdown_next;
  logic                          accept;

  logic                          held_write;
  logic [ADDR_BLOCKS_LOG2-1:0]   held_index;
  logic [127:0]                  held_data;

  // Storage powers up zeroed and is deliberately left out of reset.
  logic [127:0]                  storage [BLOCKS];

  // Offset bits and aliased upper bits take no part in block selection.
  logic                          unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_BLOCKS_LOG2+4], req_addr[3:0]};

  assign req_ready = (state == IDLE) && reset;
  assign busy      = (state != IDLE);

  // The countdown is loaded with LATENCY-1 on acceptance and the DONE state
  // is entered on the edge where it reaches zero, so the DONE edge lands
  // exactly LATENCY edges after acceptance.
  always_comb begin
    state_next     = state;
    countdown_next = countdown;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept         = 1'b1;
          countdown_next = LOAD_COUNT;
          state_next     = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (countdown != 4'd0) begin
          countdown_next = countdown - 4'd1;
        end
        if (countdown <= 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        countdown_next = 4'd0;
        state_next     = IDLE;
      end
      default: begin
        countdown_next = 4'd0;
        state_next     = IDLE;
      end
    endcase
  end

  // Control state, response and counters. An asynchronous reset drops the
  // FSM to IDLE immediately, so an aborted transaction never reaches DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      countdown   <= 4'd0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      read_count  <= 16'd0;
      write_count <= 16'd0;
    end else begin
      state      <= state_next;
      countdown  <= countdown_next;
      resp_valid <= (state == DONE);
      if (state == DONE) begin
        if (held_write) begin
          if (write_count != 16'hFFFF) begin
            write_count <= write_count + 16'd1;
          end
        end else begin
          resp_data <= storage[held_index];
          if (read_count != 16'hFFFF) begin
            read_count <= read_count + 16'd1;
          end
        end
      end
    end
  end

  // Request capture and the storage write port. The request is copied at
  // acceptance so later changes on req_addr/req_data cannot disturb it.
  always_ff @(posedge clock) begin
    if (accept && reset) begin
      held_write <= req_write;
      held_index <= req_addr[ADDR_BLOCKS_LOG2+3:4];
      held_data  <= req_data;
    end
    if ((state == DONE) && held_write && reset) begin
      storage[held_index] <= held_data;
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: self-checking bench for main_memory. One instance uses
// LATENCY=4 (table vectors, random traffic, back-to-back and reset abort),
// a second uses LATENCY=1 (back-to-back reads and counter saturation).
module tb_main_memory;

  localparam int LAT  = 4;
  localparam int LAT1 = 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr  = '0;
  logic [127:0] req_data  = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         busy;
  logic [15:0]  read_count;
  logic [15:0]  write_count;

  logic         b_req_valid = 1'b0;
  logic         b_req_write = 1'b0;
  logic [31:0]  b_req_addr  = '0;
  logic [127:0] b_req_data  = '0;
  logic         b_req_ready;
  logic         b_resp_valid;
  logic [127:0] b_resp_data;
  logic         b_busy;
  logic [15:0]  b_read_count;
  logic [15:0]  b_write_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain block array plus completion counters.
  logic [127:0] model_mem [64];
  int           model_rc;
  int           model_wc;
  logic [127:0] model_resp;

  typedef struct {
    logic         w;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [127:0] exp_resp;
    logic [15:0]  exp_rc;
    logic [15:0]  exp_wc;
  } vec_t;

  vec_t vecs [8];

  localparam logic [127:0] DATA_D = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DATA_E = 128'hDEADBEEF_CAFEF00D_11223344_55667788;
  localparam logic [127:0] DATA_F = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  always #5 clock = ~clock;

  main_memory #(.LATENCY(LAT), .ADDR_BLOCKS_LOG2(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .busy        (busy),
    .read_count  (read_count),
    .write_count (write_count)
  );

  main_memory #(.LATENCY(LAT1), .ADDR_BLOCKS_LOG2(6)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (b_req_valid),
    .req_write   (b_req_write),
    .req_addr    (b_req_addr),
    .req_data    (b_req_data),
    .req_ready   (b_req_ready),
    .resp_valid  (b_resp_valid),
    .resp_data   (b_resp_data),
    .busy        (b_busy),
    .read_count  (b_read_count),
    .write_count (b_write_count)
  );

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic int blk(input logic [31:0] a);
    return int'((a >> 4) & 32'd63);
  endfunction

  task automatic model_complete(input logic w, input logic [31:0] a,
                                input logic [127:0] d);
    if (w) begin
      model_mem[blk(a)] = d;
      if (model_wc < 65535) model_wc++;
    end else begin
      model_resp = model_mem[blk(a)];
      if (model_rc < 65535) model_rc++;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) check_output({tag, " ready_timeout"}, req_ready, 1);
  endtask

  // One transaction on the LATENCY=4 instance; checks the pulse timing and
  // returns what the outputs show in the response cycle.
  task automatic apply_stimulus(input string tag, input logic w,
                                input logic [31:0] a, input logic [127:0] d,
                                output logic [127:0] got_resp,
                                output logic [15:0] got_rc,
                                output logic [15:0] got_wc);
    wait_ready(tag);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    model_complete(w, a, d);
    got_resp = '0;
    got_rc   = '0;
    got_wc   = '0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clock);
      check_output({tag, " resp_valid"}, resp_valid, (k == LAT));
      check_output({tag, " req_ready"}, req_ready, (k == LAT));
      if (k == LAT) begin
        got_resp = resp_data;
        got_rc   = read_count;
        got_wc   = write_count;
      end
    end
  endtask

  // One transaction on the LATENCY=1 instance.
  task automatic b_txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [127:0] d, output logic [127:0] got_resp,
                       output logic [15:0] got_wc);
    int n = 0;
    while (b_req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (b_req_ready !== 1'b1) check_output({tag, " ready_timeout"}, b_req_ready, 1);
    b_req_valid = 1'b1;
    b_req_write = w;
    b_req_addr  = a;
    b_req_data  = d;
    @(posedge clock);
    #1;
    b_req_valid = 1'b0;
    b_req_data  = '0;
    got_resp = '0;
    got_wc   = '0;
    for (int k = 0; k <= LAT1; k++) begin
      @(negedge clock);
      check_output({tag, " resp_valid"}, b_resp_valid, (k == LAT1));
      if (k == LAT1) begin
        got_resp = b_resp_data;
        got_wc   = b_write_count;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] got_resp;
    logic [15:0]  got_rc;
    logic [15:0]  got_wc;
    logic [127:0] exp1;
    logic [127:0] exp2;
    logic [31:0]  r;
    logic [31:0]  a;
    logic         w;
    logic [127:0] d;
    logic [127:0] old_x;
    bit           pulse;

    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    model_rc   = 0;
    model_wc   = 0;
    model_resp = '0;

    vecs[0] = '{1'b1, 32'h0000_0010, DATA_D, 128'h0,  16'd0, 16'd1};
    vecs[1] = '{1'b0, 32'h0000_001C, 128'h0, DATA_D,  16'd1, 16'd1};
    vecs[2] = '{1'b0, 32'h0000_0020, 128'h0, 128'h0,  16'd2, 16'd1};
    vecs[3] = '{1'b1, 32'h0000_0400, DATA_E, 128'h0,  16'd2, 16'd2};
    vecs[4] = '{1'b0, 32'h0000_0000, 128'h0, DATA_E,  16'd3, 16'd2};
    vecs[5] = '{1'b0, 32'h0000_0010, 128'h0, DATA_D,  16'd4, 16'd2};
    vecs[6] = '{1'b1, 32'hFFFF_FF1F, DATA_F, DATA_D,  16'd4, 16'd3};
    vecs[7] = '{1'b0, 32'h0000_0310, 128'h0, DATA_F,  16'd5, 16'd3};

    // Reset state while reset is held low.
    #2 reset = 1'b0;
    @(negedge clock);
    #1;
    check_output("rst req_ready", req_ready, 0);
    check_output("rst busy", busy, 0);
    check_output("rst resp_valid", resp_valid, 0);
    check_output("rst resp_data", resp_data, 0);
    check_output("rst read_count", read_count, 0);
    check_output("rst write_count", write_count, 0);
    check_output("rst b_req_ready", b_req_ready, 0);
    reset = 1'b1;
    @(negedge clock);
    check_output("post_rst req_ready", req_ready, 1);
    check_output("post_rst b_req_ready", b_req_ready, 1);

    // Directed vectors: write, read-back, untouched block, aliasing.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr,
                     vecs[i].data, got_resp, got_rc, got_wc);
      check_output($sformatf("vec%0d resp_data", i), got_resp, vecs[i].exp_resp);
      check_output($sformatf("vec%0d read_count", i), got_rc, vecs[i].exp_rc);
      check_output($sformatf("vec%0d write_count", i), got_wc, vecs[i].exp_wc);
    end

    // Random traffic over a handful of blocks, upper address bits random.
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      a = (r & 32'hFFFF_FC0F) | (32'($urandom_range(0, 7)) << 4);
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus($sformatf("rnd%0d", i), w, a, d, got_resp, got_rc, got_wc);
      check_output($sformatf("rnd%0d resp_data", i), got_resp, model_resp);
      check_output($sformatf("rnd%0d read_count", i), got_rc, 16'(model_rc));
      check_output($sformatf("rnd%0d write_count", i), got_wc, 16'(model_wc));
    end

    // req_valid held through the busy period with a changed address.
    wait_ready("b2b");
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0010;
    @(posedge clock);
    #1;
    req_addr = 32'h0000_0030;
    model_complete(1'b0, 32'h0000_0010, '0);
    exp1 = model_resp;
    model_complete(1'b0, 32'h0000_0030, '0);
    exp2 = model_resp;
    for (int k = 0; k <= 2 * LAT + 1; k++) begin
      @(negedge clock);
      pulse = (k == LAT) || (k == 2 * LAT + 1);
      check_output($sformatf("b2b k%0d resp_valid", k), resp_valid, pulse);
      check_output($sformatf("b2b k%0d busy", k), busy, !pulse);
      if (k == LAT) check_output("b2b first resp_data", resp_data, exp1);
      if (k == 2 * LAT + 1) begin
        check_output("b2b second resp_data", resp_data, exp2);
        check_output("b2b read_count", read_count, 16'(model_rc));
        req_valid = 1'b0;
      end
    end

    // Reset pulsed while a write is in flight.
    old_x = model_mem[blk(32'h0000_0050)];
    wait_ready("abort");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0050;
    req_data  = 128'hFEEDFACE_00000000_FFFFFFFF_12345678;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("abort busy", busy, 0);
    check_output("abort resp_valid", resp_valid, 0);
    check_output("abort req_ready", req_ready, 0);
    check_output("abort read_count", read_count, 0);
    check_output("abort write_count", write_count, 0);
    check_output("abort resp_data", resp_data, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_output($sformatf("abort quiet%0d resp_valid", k), resp_valid, 0);
      check_output($sformatf("abort quiet%0d busy", k), busy, 0);
    end
    model_rc   = 0;
    model_wc   = 0;
    model_resp = '0;
    apply_stimulus("abort_read", 1'b0, 32'h0000_0050, '0, got_resp, got_rc, got_wc);
    check_output("abort_read resp_data", got_resp, old_x);
    check_output("abort_read read_count", got_rc, 16'd1);
    check_output("abort_read write_count", got_wc, 16'd0);

    // LATENCY=1: reads held valid are accepted every second cycle.
    b_req_valid = 1'b1;
    b_req_write = 1'b0;
    b_req_addr  = 32'h0000_0000;
    check_output("lat1 ready", b_req_ready, 1);
    @(posedge clock);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_output($sformatf("lat1 k%0d resp_valid", k), b_resp_valid, (k % 2 == 1));
      check_output($sformatf("lat1 k%0d req_ready", k), b_req_ready, (k % 2 == 1));
      if (k == 1) check_output("lat1 resp_data", b_resp_data, 0);
    end
    b_req_valid = 1'b0;
    check_output("lat1 read_count", b_read_count, 16'd4);

    // Write counter saturation.
    @(negedge clock);
    force dut1.write_count = 16'hFFFD;
    #1;
    release dut1.write_count;
    b_txn("sat1", 1'b1, 32'h0000_0020, DATA_D, got_resp, got_wc);
    check_output("sat1 write_count", got_wc, 16'hFFFE);
    b_txn("sat2", 1'b1, 32'h0000_0020, DATA_E, got_resp, got_wc);
    check_output("sat2 write_count", got_wc, 16'hFFFF);
    b_txn("sat3", 1'b1, 32'h0000_0024, DATA_F, got_resp, got_wc);
    check_output("sat3 write_count", got_wc, 16'hFFFF);
    b_txn("sat_read", 1'b0, 32'h0000_0020, '0, got_resp, got_wc);
    check_output("sat_read resp_data", got_resp, DATA_F);
    check_output("sat_read write_count", got_wc, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
